// File: rtl/covox_sample_fifo.sv
// Sample FIFO between the CPU covox port and the sound mixer.
// CPU pushes arrive in bursts; a programmable divider pops one sample per period.
module covox_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DIV_W-1:0]      rate_div,
  input  logic                  clr_flags,
  output logic [7:0]            covox_din,
  output logic                  covox_wr,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  low_water,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DIV_W-1:0]      CNT_ONE  = DIV_W'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DIV_W-1:0]      div_cnt;

  logic tick_p0, pop_p0, push_p0, underrun_set_p0, overrun_set_p0;

  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign low_water = (level <= LVL_HALF);

  // Stage p0: divider tick and push/pop arbitration; clear discards both
  assign tick_p0         = enable && (div_cnt == '0);
  assign pop_p0          = tick_p0 && !empty && !clear;
  assign push_p0         = wr_stb && (!full || pop_p0) && !clear;
  assign underrun_set_p0 = tick_p0 && empty && !clear;
  assign overrun_set_p0  = wr_stb && full && !pop_p0 && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || clear || div_cnt == '0) begin
      div_cnt <= rate_div;
    end else begin
      div_cnt <= div_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (pop_p0)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_p0) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push_p0, pop_p0})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sample storage carries no reset; only pointers and level define validity
  always_ff @(posedge clk) begin
    if (push_p0) mem[wr_ptr] <= wr_data;
  end

  // Stage p1: registered sample and its one-cycle strobe to the mixer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      covox_din <= 8'h80;
      covox_wr  <= 1'b0;
    end else begin
      covox_wr <= pop_p0;
      if (pop_p0) covox_din <= mem[rd_ptr];
    end
  end

  // Set events take precedence over clr_flags in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (underrun_set_p0)  underrun <= 1'b1;
      else if (clr_flags)   underrun <= 1'b0;
      if (overrun_set_p0)   overrun  <= 1'b1;
      else if (clr_flags)   overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_covox_sample_fifo.sv
// Randomized and directed bench for covox_sample_fifo against a queue-based
// model of the sample buffer, playback period and sticky flags.
module tb_covox_sample_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DIV_W      = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_stb;
  logic [7:0]        wr_data;
  logic              enable;
  logic              clear;
  logic [DIV_W-1:0]  rate_div;
  logic              clr_flags;
  logic [7:0]        covox_din;
  logic              covox_wr;
  logic [DEPTH_LOG2:0] level;
  logic              full, empty, low_water, underrun, overrun;

  covox_sample_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_data(wr_data),
    .enable(enable), .clear(clear), .rate_div(rate_div), .clr_flags(clr_flags),
    .covox_din(covox_din), .covox_wr(covox_wr), .level(level), .full(full),
    .empty(empty), .low_water(low_water), .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: sample queue, cycles elapsed in the current period,
  // period latched at the last reload, last emitted sample, sticky flags.
  logic [7:0] q[$];
  int         m_el, m_per;
  logic [7:0] m_din;
  bit         m_wr, m_uf, m_of;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_el = 0; m_per = 0; m_din = 8'h80; m_wr = 0; m_uf = 0; m_of = 0;
  endtask

  function automatic bit model_tick_next();
    return m_el == m_per;
  endfunction

  task automatic model_cycle(input bit w, input logic [7:0] d, input bit en,
                             input bit clr, input int rd, input bit cf);
    bit tick;
    tick = en && (m_el == m_per);
    if (cf) begin m_uf = 0; m_of = 0; end
    m_wr = 0;
    if (clr) begin
      q.delete();
      m_el = 0; m_per = rd;
    end else begin
      if (tick) begin
        if (q.size() > 0) begin m_din = q.pop_front(); m_wr = 1; end
        else m_uf = 1;
      end
      if (w) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_of = 1;
      end
      if (!en || tick) begin m_el = 0; m_per = rd; end
      else m_el++;
    end
  endtask

  task automatic check_all();
    check("covox_wr",  covox_wr,  m_wr);
    check("covox_din", covox_din, m_din);
    check("level",     level,     q.size());
    check("full",      full,      q.size() == DEPTH);
    check("empty",     empty,     q.size() == 0);
    check("low_water", low_water, q.size() <= DEPTH / 2);
    check("underrun",  underrun,  m_uf);
    check("overrun",   overrun,   m_of);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare after it.
  task automatic step(input bit w, input logic [7:0] d, input bit en,
                      input bit clr, input int rd, input bit cf);
    wr_stb = w; wr_data = d; enable = en; clear = clr;
    rate_div = DIV_W'(rd); clr_flags = cf;
    @(posedge clk);
    model_cycle(w, d, en, clr, rd, cf);
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"},   covox_din, 8'h80);
    check({tag, "_wr"},    covox_wr,  1'b0);
    check({tag, "_level"}, level,     0);
    check({tag, "_empty"}, empty,     1'b1);
    check({tag, "_full"},  full,      1'b0);
    check({tag, "_lowwm"}, low_water, 1'b1);
    check({tag, "_uf"},    underrun,  1'b0);
    check({tag, "_of"},    overrun,   1'b0);
  endtask

  initial begin
    int strobes;
    logic [7:0] seen[$];
    logic [7:0] din_before;
    bit found;
    bit w, en, clr, cf;
    int rd, wprob;

    rst_n = 1'b0; wr_stb = 0; wr_data = 0; enable = 0; clear = 0;
    rate_div = 0; clr_flags = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Three samples played at a 4-cycle period, then an underrun
    for (int i = 0; i < 3; i++) step(1, 8'(8'h11 * (i + 1)), 0, 0, 3, 0);
    strobes = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, 8'h00, 1, 0, 3, 0);
      if (covox_wr) begin
        strobes++;
        check("t2_order", covox_din, 8'(8'h11 * strobes));
      end
    end
    check("t2_strobes", strobes, 3);
    check("t2_hold", covox_din, 8'h33);
    check("t2_underrun", underrun, 1'b1);

    // Overfill by one, confirm the 17th is dropped on replay
    step(0, 8'h00, 0, 1, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
    check("t3_level", level, 16);
    check("t3_full", full, 1'b1);
    check("t3_overrun", overrun, 1'b1);
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00, 1, 0, 0, 0);
      if (covox_wr) seen.push_back(covox_din);
    end
    check("t3_replay_n", seen.size(), 16);
    if (seen.size() > 0) check("t3_replay_last", seen[seen.size() - 1], 8'h4F);
    step(0, 8'h00, 0, 0, 0, 1);
    check("t3_clr_of", overrun, 1'b0);

    // Full FIFO, tick every cycle, push every cycle
    step(0, 8'h00, 0, 1, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(16 + i), 1, 0, 0, 0);
      check("t4_level", level, 16);
      check("t4_strobe", covox_wr, 1'b1);
      check("t4_data", covox_din, 8'(i));
    end
    check("t4_overrun", overrun, 1'b0);

    // Push in the tick cycle of an empty FIFO
    step(0, 8'h00, 0, 1, 3, 1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (model_tick_next() && q.size() == 0) found = 1;
      else step(0, 8'h00, 1, 0, 3, 1);
    end
    check("t5_tick_found", found, 1'b1);
    step(1, 8'hA5, 1, 0, 3, 0);
    check("t5_underrun", underrun, 1'b1);
    check("t5_level", level, 1);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(0, 8'h00, 1, 0, 3, 0);
      if (covox_wr) found = 1;
    end
    check("t5_emitted", found, 1'b1);
    check("t5_data", covox_din, 8'hA5);

    // Clear landing on a tick with 5 entries
    step(0, 8'h00, 0, 1, 2, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 2, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (model_tick_next()) found = 1;
      else step(0, 8'h00, 1, 0, 2, 0);
    end
    check("t6_tick_found", found, 1'b1);
    check("t6_level_pre", level, 5);
    din_before = m_din;
    step(0, 8'h00, 1, 1, 2, 1);
    check("t6_level", level, 0);
    check("t6_no_wr", covox_wr, 1'b0);
    check("t6_din_hold", covox_din, din_before);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 2, 0);
    check("t6_underrun", underrun, 1'b1);

    // Randomized traffic with bursty write density
    en = 1; rd = 1; wprob = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) wprob = $urandom_range(10, 90);
      if ($urandom_range(0, 99) < 2) en = !en;
      if ($urandom_range(0, 99) < 3) rd = $urandom_range(0, 4);
      w   = $urandom_range(0, 99) < wprob;
      clr = $urandom_range(0, 199) == 0;
      cf  = $urandom_range(0, 99) < 3;
      step(w, 8'($urandom), en, clr, rd, cf);
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) step(1, 8'($urandom), 1, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step($urandom_range(0, 1), 8'($urandom), 1, 0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/covox_sample_fifo.md
Name: covox_sample_fifo

Overview:
- Buffers 8-bit covox samples written by the CPU and replays them at a programmable fixed rate.
- Output is a one-cycle covox_wr strobe plus data, which drives the sound mixer's covox_wr/din inputs directly.
- This decouples CPU write timing from sample playback, so software can fill the buffer in bursts.
- Sits between the port decoder and the sound mixer, in the sound clock domain.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_stb  in  1  one-cycle CPU write strobe; pushes wr_data.
- wr_data  in  8  sample to push.
- enable  in  1  playback enable.
- clear  in  1  synchronous flush; one-cycle pulse or level.
- rate_div  in  DIV_W  playback period minus one, in clk cycles.
- clr_flags  in  1  clears the sticky underrun/overrun flags.
- covox_din  out  8  current sample to the mixer.
- covox_wr  out  1  one-cycle strobe marking that covox_din has been updated.
- level  out  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2.
- full  out  1  level == 2^DEPTH_LOG2.
- empty  out  1  level == 0.
- low_water  out  1  level <= 2^(DEPTH_LOG2-1); used as the CPU refill request.
- underrun  out  1  sticky: a tick occurred while the FIFO was empty.
- overrun  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - read/write pointers = 0, level = 0.
  - divider counter = 0.
  - covox_din = 8'h80 (midscale), covox_wr = 0.
  - underrun = 0, overrun = 0.
  - Flags are combinational from level: empty = 1, full = 0, low_water = 1.
- Storage: 2^DEPTH_LOG2 x 8 register array with circular pointers that wrap modulo depth. level is a counter, not pointer subtraction.
- Divider:
  - When enable = 0: counter is loaded with rate_div every cycle and no ticks occur.
  - When enable = 1: counter decrements each cycle. At 0 it asserts an internal tick for that cycle and reloads rate_div.
  - Tick period is rate_div+1 cycles; rate_div = 0 gives a tick every cycle.
  - A rate_div change takes effect at the next reload only.
- Pop on tick:
  - If the FIFO is not empty in the tick cycle, the head entry is read and the read pointer advances.
  - On the next clk edge, covox_din gets the entry and covox_wr = 1 for exactly one cycle. Latency from tick to strobe is 1 cycle.
  - If the FIFO is empty in the tick cycle: no pop, covox_wr stays 0, covox_din holds, and underrun is set.
- Push:
  - wr_stb with level < depth writes at the write pointer, which then advances.
  - wr_stb when full is dropped and sets overrun, except when a pop occurs in the same cycle. In that case the push is accepted and level is unchanged.
- Simultaneous push and pop:
  - If not empty: both occur and level is unchanged.
  - If empty: the pop is not performed (underrun is set) and the push is stored, so level becomes 1. There is no write-through bypass.
- level update: +1 for push only, -1 for pop only, unchanged for both or neither.
- clear (priority over push/pop in the same cycle):
  - pointers and level return to 0, and the counter reloads rate_div.
  - The in-flight push and pop are discarded and no covox_wr is issued next cycle.
  - covox_din holds its value; sticky flags are unchanged.
- clr_flags: clears underrun and overrun. A set event in the same cycle wins, so the flag stays 1.
- enable falling: a pending covox_wr from a tick in the previous cycle still issues. FIFO contents are retained.
- Reset asserted mid-operation clears everything asynchronously; there is no partial state.

Test Plan:
- Reset, then check outputs: covox_din = 8'h80, empty = 1, low_water = 1, level = 0, covox_wr = 0.
- Push 8'h11, 22, 33 with enable = 0, then set rate_div = 3 and enable = 1. Required: covox_wr pulses every 4 cycles carrying 11, 22, 33 in order. A 4th tick sets underrun and gives no strobe; covox_din stays 33.
- Push 17 samples, enable = 0. Required: level = 16, full = 1, overrun = 1, and the 17th value is absent on replay. Then clr_flags gives overrun = 0.
- Fill to full with rate_div = 0, enable = 1, and push on every cycle. Required: no overrun, level stays 16, and covox_wr is asserted every cycle with data in push order.
- Push in the same cycle as a tick on an empty FIFO. Required: underrun = 1, level = 1, and the sample is emitted on the following tick.
- With 5 entries, assert clear in a tick cycle. Required: level = 0, no covox_wr next cycle, covox_din unchanged, and the next tick reports underrun.
